// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC digital core.
package sar_adc_pkg;

  localparam int unsigned SAR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_HOLD
  } sar_state_e;

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Pad/analog-side signal bundle of the SAR ADC core; master drives requests and
// comparator/DAC test inputs, slave is the controller.
interface sar_adc_ctrl_if #(
  parameter int unsigned WIDTH = sar_adc_pkg::SAR_WIDTH
);

  logic             start;
  logic             cmp_sel;
  logic             cmp_int;
  logic             cmp_ext;
  logic             dac_sel;
  logic [WIDTH-1:0] dac_ext;
  logic             q_out;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] data_out;
  logic             done;

  modport master (
    output start, cmp_sel, cmp_int, cmp_ext, dac_sel, dac_ext,
    input  q_out, dac_code, data_out, done
  );

  modport slave (
    input  start, cmp_sel, cmp_int, cmp_ext, dac_sel, dac_ext,
    output q_out, dac_code, data_out, done
  );

endinterface

// File: rtl/sar_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sar_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: comparator/DAC source muxes and the successive-approximation FSM.
// Define SAR_START_SYNC_EN to pass start through a 2-flop synchronizer first.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  sar_adc_ctrl_if.slave bus
);

  localparam int unsigned    IdxW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);
  localparam logic [IdxW-1:0] IdxOne = IdxW'(1);
  localparam logic [WIDTH-1:0] SarInit = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_e       state_q;
  logic [WIDTH-1:0] sar_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] sar_trial;
  logic [IdxW-1:0]  idx_q;
  logic             done_q;
  logic             start_s;
  logic             start_q;
  logic             start_rise;

`ifdef SAR_START_SYNC_EN
  sar_sync2 u_start_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.start),
    .q_o   (start_s)
  );
`else
  assign start_s = bus.start;
`endif

  assign start_rise = start_s & ~start_q;

  // Both muxes are purely combinational so they stay usable while in reset.
  assign bus.q_out    = bus.cmp_sel ? bus.cmp_ext : bus.cmp_int;
  assign bus.dac_code = bus.dac_sel ? bus.dac_ext : sar_q;
  assign bus.data_out = data_q;
  assign bus.done     = done_q;

  // Resolve the current bit and arm the next trial bit in one step.
  always_comb begin
    sar_trial = sar_q;
    if (!bus.q_out) sar_trial[idx_q] = 1'b0;
    if (idx_q != '0) sar_trial[idx_q - IdxOne] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sar_q   <= '0;
      idx_q   <= IdxMax;
      data_q  <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= start_s;
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (start_rise) begin
            sar_q   <= SarInit;
            idx_q   <= IdxMax;
            done_q  <= 1'b0;
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          sar_q <= sar_trial;
          if (idx_q != '0) begin
            idx_q <= idx_q - IdxOne;
          end else begin
            data_q  <= sar_trial;
            done_q  <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: comparator/DAC muxes, conversions with a
// comparator model, extremes, ignored restarts and reset abort.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       model_en = 1'b0;
  logic       cmp_int_man = 1'b0;
  logic [7:0] target = 8'h00;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  sar_adc_ctrl_if #(.WIDTH(8)) bus ();

  sar_adc_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Comparator model uses >= so a conversion lands exactly on the target code.
  always_comb bus.cmp_int = model_en ? (target >= bus.dac_code) : cmp_int_man;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input logic [7:0] exp_res, input logic chk_trials,
                          input logic mid_pulse);
    int         n;
    logic [7:0] want;
    exp_q.push_back(exp_res);
    @(negedge clk);
    bus.start = 1'b1;
`ifdef SAR_START_SYNC_EN
    repeat (2) @(posedge clk);
`endif
    @(posedge clk);
    #1;
    check("done_low_after_start", bus.done, 1'b0);
    check("first_trial", bus.dac_code, 8'h80);
    n = 0;
    while (n < 20 && bus.done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (chk_trials && n == 1) check("trial_1", bus.dac_code, 8'hC0);
      if (chk_trials && n == 2) check("trial_2", bus.dac_code, 8'hA0);
      if (mid_pulse && n == 2) bus.start = 1'b0;
      if (mid_pulse && n == 3) bus.start = 1'b1;
    end
    check("done_latency", n, 8);
    want = exp_q.pop_front();
    check("data_out", bus.data_out, want);
    // start still held high: HOLD must not restart
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", bus.done, 1'b1);
    check("hold_data", bus.data_out, want);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic pi[4];
    logic pe[4];
    pi = '{1'b0, 1'b1, 1'b0, 1'b1};
    pe = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.start   = 1'b0;
    bus.cmp_sel = 1'b0;
    bus.cmp_ext = 1'b0;
    bus.dac_sel = 1'b0;
    bus.dac_ext = 8'h00;
    cmp_int_man = 1'b0;

    // Comparator mux exercised while reset is held.
    for (int s = 0; s < 2; s++) begin
      bus.cmp_sel = s[0];
      for (int i = 0; i < 4; i++) begin
        cmp_int_man = pi[i];
        bus.cmp_ext = pe[i];
        #5;
        check(s == 0 ? "q_out_int" : "q_out_ext", bus.q_out, s == 0 ? pi[i] : pe[i]);
      end
    end
    bus.cmp_sel = 1'b0;

    check("rst_done", bus.done, 1'b0);
    check("rst_data", bus.data_out, 8'h00);
    bus.dac_sel = 1'b1;
    bus.dac_ext = 8'h55;
    #5;
    check("dac_ext", bus.dac_code, 8'h55);
    bus.dac_sel = 1'b0;
    #5;
    check("dac_sar_rst", bus.dac_code, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    model_en = 1'b1;
    target   = 8'hA7;
    run_conv(8'hA7, 1'b1, 1'b0);

    model_en    = 1'b0;
    cmp_int_man = 1'b1;
    run_conv(8'hFF, 1'b0, 1'b0);

    cmp_int_man = 1'b0;
    run_conv(8'h00, 1'b0, 1'b1);

    model_en = 1'b1;
    target   = 8'h5A;
    run_conv(8'h5A, 1'b0, 1'b0);

    // Abort a conversion with reset after 4 cycles.
    @(negedge clk);
    bus.start = 1'b1;
`ifdef SAR_START_SYNC_EN
    repeat (2) @(posedge clk);
`endif
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_done", bus.done, 1'b0);
    check("abort_data", bus.data_out, 8'h00);
    check("abort_dac", bus.dac_code, 8'h00);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    target = 8'h3C;
    run_conv(8'h3C, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
